axis_uart_tx: RTL and testbench

// AXI-Stream slave that accepts WIDTH-bit words and serializes them as UART frames on tx.

---
 rtl/axis_uart_tx.sv | 159 +++++++++++++++
 tb/tb_axis_uart_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_uart_tx                                               |
// | Description : AXI-Stream slave that serializes WIDTH-bit words as UART   |
// |               frames: start bit (0), WIDTH data bits LSB first, stop     |
// |               bit (1), no parity. A one-entry holding register accepts   |
// |               the next word while the current frame shifts out, so       |
// |               back-to-back words produce contiguous frames.              |
// | Ports       : clk            system clock, rising edge                   |
// |               rst            asynchronous reset, active-high             |
// |               s_axis_tdata   word to transmit                            |
// |               s_axis_tvalid  upstream has a valid word                   |
// |               s_axis_tready  holding register empty                      |
// |               tx             UART serial output, idle high, registered   |
// |               busy           high while a frame is on tx, registered     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axis_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic             tx,
  output logic             busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_data_q;
  logic             hold_full_q;
  logic             tx_q;
  logic             busy_q;

  logic             accept_d;
  logic             bit_end_d;

  // Accept only into an empty holding register; the drain edge itself
  // cannot accept because hold_full_q is still set on that edge.
  assign accept_d  = s_axis_tvalid && !hold_full_q;
  assign bit_end_d = (baud_cnt_q == BAUD_LAST);

  assign s_axis_tready = ~hold_full_q;
  assign tx            = tx_q;
  assign busy          = busy_q;

  // tx_q/busy_q are written on the edge that enters a state, so they always
  // show the value belonging to the state the FSM is currently in.
  // The shifter is consumed LSB first: tx carries shift_q[0] of the
  // pre-shift word, i.e. the current bit_idx of the original word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      if (accept_d) begin
        hold_data_q <= s_axis_tdata;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
          if (hold_full_q) begin
            shift_q     <= hold_data_q;
            hold_full_q <= 1'b0;
            state_q     <= START;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end

        START: begin
          if (bit_end_d) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= DATA;
            tx_q       <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (bit_end_d) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == IDX_LAST) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (bit_end_d) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            if (hold_full_q) begin
              // Chain straight into the next frame with no idle bit time.
              shift_q     <= hold_data_q;
              hold_full_q <= 1'b0;
              state_q     <= START;
              tx_q        <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q    <= IDLE;
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
          tx_q       <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axis_uart_tx                                            |
// | Description : Self-checking bench for axis_uart_tx (WIDTH=8,             |
// |               CLKS_PER_BIT=4). Accepted words are queued as expected     |
// |               frames; a tx monitor decodes frames and compares them.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_axis_uart_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (WIDTH + 2) * CPB;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic             tx;
  logic             busy;

  int errors      = 0;
  int checks      = 0;
  int frames_done = 0;
  int last_gap    = 0;
  int idle_cnt    = 0;
  logic [WIDTH-1:0] exp_q[$];

  axis_uart_tx #(
    .WIDTH        (WIDTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .tx            (tx),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [WIDTH-1:0] d, input int max_wait);
    bit ok;
    ok       = 1'b0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    for (int i = 0; i < max_wait; i++) begin
      if (s_tready === 1'b1) begin
        exp_q.push_back(d);
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int max_wait);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      if (busy === 1'b0 && s_tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_idle", 32'(ok), 32'd1);
  endtask

  // tx monitor: decodes each frame cycle by cycle and compares against the queue.
  initial begin
    logic [9:0]       bits;
    logic [WIDTH-1:0] exp;
    bit               ok;
    bit               aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) begin
        idle_cnt++;
      end else begin
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        exp      = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        last_gap = idle_cnt;
        idle_cnt = 0;
        ok       = 1'b1;
        aborted  = 1'b0;
        bits     = '0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == 0) bits[k / CPB] = tx;
          else if (tx !== bits[k / CPB]) ok = 1'b0;
          if (busy !== 1'b1) ok = 1'b0;
        end
        if (!aborted) begin
          check("frame_format", 32'({bits[0], bits[9], ok}), 32'b011);
          check("frame_data", 32'(bits[8:1]), 32'(exp));
          frames_done++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  f0;
    int  cnt;
    bit  quiet;

    rst      = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;

    // 1. Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_tready", 32'(s_tready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_tready", 32'(s_tready), 32'd1);

    // 2. Single word 0xA5.
    f0 = frames_done;
    send(8'hA5, 10);
    check("a5_tready_low", 32'(s_tready), 32'd0);
    check("a5_busy_before_load", 32'(busy), 32'd0);
    @(negedge clk);
    check("a5_tready_back", 32'(s_tready), 32'd1);
    check("a5_start_tx", 32'(tx), 32'd0);
    check("a5_busy_rise", 32'(busy), 32'd1);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
      else break;
    end
    check("a5_busy_cycles", 32'(cnt), 32'(FRAME));
    check("a5_frames", 32'(frames_done), 32'(f0 + 1));
    check("a5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3. Back-to-back 0x00 then 0xFF with tvalid held.
    f0       = frames_done;
    s_tdata  = 8'h00;
    s_tvalid = 1'b1;
    check("b2b_ready0", 32'(s_tready), 32'd1);
    exp_q.push_back(8'h00);
    @(negedge clk);
    s_tdata = 8'hFF;
    check("b2b_hold_full", 32'(s_tready), 32'd0);
    @(negedge clk);
    check("b2b_ready_in_start", 32'(s_tready), 32'd1);
    check("b2b_start_busy", 32'(busy), 32'd1);
    check("b2b_start_tx", 32'(tx), 32'd0);
    exp_q.push_back(8'hFF);
    @(negedge clk);
    s_tvalid = 1'b0;
    check("b2b_ff_held", 32'(s_tready), 32'd0);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_tready === 1'b1) break;
      cnt++;
    end
    check("b2b_tready_low_cycles", 32'(cnt), 32'(FRAME - 1));
    wait_idle(200);
    check("b2b_frames", 32'(frames_done), 32'(f0 + 2));
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    check("b2b_gap", 32'(last_gap), 32'd0);

    // 4. 0x3C presented while the holding register is full.
    f0 = frames_done;
    send(8'h11, 10);
    send(8'h22, 60);
    check("stall_tready_low", 32'(s_tready), 32'd0);
    send(8'h3C, 100);
    wait_idle(300);
    check("stall_frames", 32'(frames_done), 32'(f0 + 3));
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5. Reset during data bit 3 of 0x5A with 0x77 held.
    f0 = frames_done;
    send(8'h5A, 10);
    send(8'h77, 60);
    repeat (16) @(negedge clk);
    check("mid_bit3_tx", 32'(tx), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_held", 32'(s_tready), 32'd0);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tready", 32'(s_tready), 32'd1);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || s_tready !== 1'b1) quiet = 1'b0;
    end
    check("mid_rst_quiet", 32'(quiet), 32'd1);
    check("mid_rst_no_frames", 32'(frames_done), 32'(f0));
    send(8'h81, 10);
    wait_idle(100);
    check("post_rst_81_frames", 32'(frames_done), 32'(f0 + 1));
    check("post_rst_81_queue", 32'(exp_q.size()), 32'd0);

    // 6. tdata toggling with tvalid low.
    f0    = frames_done;
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      s_tdata  = 8'($urandom);
      s_tvalid = 1'b0;
      if (tx !== 1'b1 || busy !== 1'b0 || s_tready !== 1'b1) quiet = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("noise_quiet", 32'(quiet), 32'd1);
    check("noise_tready", 32'(s_tready), 32'd1);
    check("noise_frames", 32'(frames_done), 32'(f0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
